intr_timer_ctrl: RTL and testbench

- Memory-mapped interrupt controller and programmable timer on the CPU data-memory port.
- Upstream of the CPU's interrupt input. Consumes the CPU's `memAddr`/`memCe`/`memWr`/`wtData` and returns `rdData`.
- Synchronises 5 external IRQ lines, latches them into pending bits, applies a mask, and drives the 6-bit `intr` vector that CP0 samples.
- Source 5 is the internal timer-compare event, OR'd with the CP0 `intimer` output.

---
 rtl/intr_timer_ctrl_pkg.sv | 25 ++
 rtl/intr_timer_ctrl_irq_sync.sv | 41 ++++
 rtl/intr_timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_intr_timer_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_timer_ctrl_pkg.sv
// Shared constants for the interrupt controller / timer block:
// register indices, TCTRL bit positions, source numbering and reset polarity.
package intr_timer_ctrl_pkg;

    // Register indices, taken from memAddr[4:2]
    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_EDGE  = 3'd2;
    localparam logic [2:0] REG_TCNT  = 3'd3;
    localparam logic [2:0] REG_TCMP  = 3'd4;
    localparam logic [2:0] REG_TCTRL = 3'd5;

    // TCTRL bit positions
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;

    // Interrupt source numbering
    localparam int N_EXT   = 5;
    localparam int TMR_SRC = 5;
    localparam int N_SRC   = 6;

    // Level of rst that holds the block in reset
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/intr_timer_ctrl_irq_sync.sv
// Multi-flop synchroniser for the external IRQ bus, plus one extra flop
// holding the previous synchronised value for rising-edge detection.
module irq_sync
    import intr_timer_ctrl_pkg::*;
#(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] sync_dly
);

    logic [STAGES-1:0][W-1:0] stage_q;
    logic [STAGES-1:0][W-1:0] stage_d;
    logic [W-1:0]             dly_q;
    logic [W-1:0]             dly_d;

    // Shift the raw inputs down the synchroniser chain; the last stage feeds the edge flop
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], async_in};
        dly_d   = stage_q[STAGES-1];
    end

    // Synchroniser and edge-detect flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            stage_q <= '0;
            dly_q   <= '0;
        end else begin
            stage_q <= stage_d;
            dly_q   <= dly_d;
        end
    end

    assign sync_out = stage_q[STAGES-1];
    assign sync_dly = dly_q;

endmodule

// File: rtl/intr_timer_ctrl.sv
// Memory-mapped interrupt controller with a programmable compare timer.
// Five synchronised external IRQs plus the timer match feed a pending
// register; masked pending bits are registered onto the CPU intr vector.
module intr_timer_ctrl
    import intr_timer_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          SYNC_STAGES = 2,
    parameter int          TMR_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        sel,
    input  logic [4:0]  irq_ext,
    input  logic        intimer,
    output logic [5:0]  intr
);

    logic [2:0]       reg_idx;
    logic             wr_en;
    logic             unused_addr;

    logic [N_EXT-1:0] s;
    logic [N_EXT-1:0] s_d;
    logic [N_EXT-1:0] ext_set;
    logic             timer_match;

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_EXT-1:0] edge_q, edge_d;
    logic [TMR_W-1:0] tcnt_q, tcnt_d;
    logic [TMR_W-1:0] tcmp_q, tcmp_d;
    logic [1:0]       tctrl_q, tctrl_d;
    logic [N_SRC-1:0] intr_q, intr_d;

    assign sel         = memCe && (memAddr[31:8] == BASE_ADDR[31:8]);
    assign reg_idx     = memAddr[4:2];
    assign wr_en       = sel && memWr;
    assign unused_addr = ^{memAddr[7:5], memAddr[1:0]};

    irq_sync #(
        .W      (N_EXT),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (irq_ext),
        .sync_out (s),
        .sync_dly (s_d)
    );

    // Combinational read mux; unmapped indices and misses return zero
    always_comb begin
        rdData = '0;
        if (sel) begin
            case (reg_idx)
                REG_PEND:  rdData = {26'd0, pend_q};
                REG_MASK:  rdData = {26'd0, mask_q};
                REG_EDGE:  rdData = {27'd0, edge_q};
                REG_TCNT:  rdData = 32'(tcnt_q);
                REG_TCMP:  rdData = 32'(tcmp_q);
                REG_TCTRL: rdData = {30'd0, tctrl_q};
                default:   rdData = '0;
            endcase
        end
    end

    // Timer step: count up, or on a compare match either reload or stop; CPU writes override
    always_comb begin
        timer_match = 1'b0;
        tcnt_d      = tcnt_q;
        tcmp_d      = tcmp_q;
        tctrl_d     = tctrl_q;
        if (tctrl_q[TCTRL_EN]) begin
            if (tcnt_q == tcmp_q) begin
                timer_match = 1'b1;
                if (tctrl_q[TCTRL_AUTO]) begin
                    tcnt_d = '0;
                end else begin
                    tctrl_d[TCTRL_EN] = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q + TMR_W'(1);
            end
        end
        if (wr_en) begin
            case (reg_idx)
                REG_TCNT:  tcnt_d  = wtData[TMR_W-1:0];
                REG_TCMP:  tcmp_d  = wtData[TMR_W-1:0];
                REG_TCTRL: tctrl_d = wtData[1:0];
                default:   ;
            endcase
        end
    end

    // Pending/mask/edge update: W1C clears first, then new events set, so a set always wins
    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        ext_set = (edge_q & s & ~s_d) | (~edge_q & s);
        pend_d  = pend_q;
        if (wr_en) begin
            case (reg_idx)
                REG_PEND: pend_d = pend_q & ~wtData[N_SRC-1:0];
                REG_MASK: mask_d = wtData[N_SRC-1:0];
                REG_EDGE: edge_d = wtData[N_EXT-1:0];
                default:  ;
            endcase
        end
        pend_d = pend_d | {timer_match, ext_set};
        intr_d = pend_q & mask_q;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            pend_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            tcnt_q  <= '0;
            tcmp_q  <= '0;
            tctrl_q <= '0;
            intr_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            tctrl_q <= tctrl_d;
            intr_q  <= intr_d;
        end
    end

    assign intr = {intr_q[TMR_SRC] | intimer, intr_q[N_EXT-1:0]};

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// Directed testbench for intr_timer_ctrl: reset, edge/level IRQs,
// auto-reload and one-shot timer, address decode and masking.
module tb_intr_timer_ctrl;
    import intr_timer_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        memCe;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        sel;
    logic [4:0]  irq_ext;
    logic        intimer;
    logic [5:0]  intr;

    int checks = 0;
    int errors = 0;

    intr_timer_ctrl #(
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2),
        .TMR_W       (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memCe   (memCe),
        .memWr   (memWr),
        .memAddr (memAddr),
        .wtData  (wtData),
        .rdData  (rdData),
        .sel     (sel),
        .irq_ext (irq_ext),
        .intimer (intimer),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write_addr(input logic [31:0] addr, input logic [31:0] data);
        memCe = 1'b1; memWr = 1'b1; memAddr = addr; wtData = data;
        @(posedge clk);
        #1;
        memCe = 1'b0; memWr = 1'b0; wtData = '0;
    endtask

    task automatic cpu_write(input logic [2:0] idx, input logic [31:0] data);
        cpu_write_addr(BASE + {27'd0, idx, 2'b00}, data);
    endtask

    task automatic cpu_read_addr(input logic [31:0] addr, output logic [31:0] data, output logic sel_o);
        memCe = 1'b1; memWr = 1'b0; memAddr = addr;
        #1;
        data  = rdData;
        sel_o = sel;
        memCe = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] idx, output logic [31:0] data);
        logic s_o;
        cpu_read_addr(BASE + {27'd0, idx, 2'b00}, data, s_o);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        cpu_write(REG_MASK, 32'h3F);
        cpu_write(REG_TCTRL, 32'h1);
        tick(1);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h20) begin errors++; $display("[TB] FAIL tcmp0_pend: got %h expected %h", v, 32'h20); end
        cpu_read(REG_TCTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL tcmp0_tctrl: got %h expected %h", v, 32'h0); end
        tick(1);
        checks++; if (intr !== 6'h20) begin errors++; $display("[TB] FAIL pre_reset_intr: got %h expected %h", intr, 6'h20); end
        rst = 1'b0;
        #1;
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL reset_intr: got %h expected %h", intr, 6'h00); end
        checks++; if (rdData !== 32'h0) begin errors++; $display("[TB] FAIL reset_rddata: got %h expected %h", rdData, 32'h0); end
        for (int i = 0; i < 6; i++) begin
            cpu_read(3'(i), v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, v, 32'h0); end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            cpu_read(3'(i), v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_reg%0d: got %h expected %h", i, v, 32'h0); end
        end
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL post_reset_intr: got %h expected %h", intr, 6'h00); end
    endtask

    task automatic test_edge();
        logic [31:0] v;
        cpu_write(REG_EDGE, 32'h01);
        cpu_write(REG_MASK, 32'h01);
        irq_ext[0] = 1'b1;
        tick(3);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h01) begin errors++; $display("[TB] FAIL edge_pend: got %h expected %h", v, 32'h01); end
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL edge_intr_early: got %h expected %h", intr, 6'h00); end
        tick(1);
        checks++; if (intr !== 6'h01) begin errors++; $display("[TB] FAIL edge_intr: got %h expected %h", intr, 6'h01); end
        cpu_write(REG_PEND, 32'h01);
        checks++; if (intr !== 6'h01) begin errors++; $display("[TB] FAIL edge_w1c_lat: got %h expected %h", intr, 6'h01); end
        tick(1);
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL edge_w1c_intr: got %h expected %h", intr, 6'h00); end
        tick(3);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h0 || intr !== 6'h00) begin errors++; $display("[TB] FAIL edge_held: got pend %h intr %h expected 0 0", v, intr); end
        irq_ext[0] = 1'b0;
        tick(3);
        cpu_write(REG_EDGE, 32'h0);
        cpu_write(REG_MASK, 32'h0);
    endtask

    task automatic test_level();
        logic [31:0] v;
        cpu_write(REG_MASK, 32'h02);
        irq_ext[1] = 1'b1;
        tick(3);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h02) begin errors++; $display("[TB] FAIL level_pend: got %h expected %h", v, 32'h02); end
        cpu_write(REG_PEND, 32'h02);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h02) begin errors++; $display("[TB] FAIL level_reassert: got %h expected %h", v, 32'h02); end
        checks++; if (intr !== 6'h02) begin errors++; $display("[TB] FAIL level_intr: got %h expected %h", intr, 6'h02); end
        irq_ext[1] = 1'b0;
        tick(3);
        cpu_write(REG_PEND, 32'h02);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL level_clear: got %h expected %h", v, 32'h0); end
        tick(1);
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL level_intr_clear: got %h expected %h", intr, 6'h00); end
        cpu_write(REG_MASK, 32'h0);
    endtask

    task automatic test_timer_auto();
        logic [31:0] v;
        logic [31:0] exp_tcnt [7] = '{1, 2, 3, 4, 0, 1, 2};
        logic        exp_pend5[7] = '{0, 0, 0, 0, 1, 1, 1};
        logic        exp_intr5[7] = '{0, 0, 0, 0, 0, 1, 1};
        cpu_write(REG_MASK, 32'h20);
        cpu_write(REG_TCMP, 32'h4);
        cpu_write(REG_TCTRL, 32'h3);
        cpu_read(REG_TCNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL auto_tcnt_start: got %h expected %h", v, 32'h0); end
        for (int i = 0; i < 7; i++) begin
            tick(1);
            cpu_read(REG_TCNT, v);
            checks++; if (v !== exp_tcnt[i]) begin errors++; $display("[TB] FAIL auto_tcnt step %0d: got %h expected %h", i, v, exp_tcnt[i]); end
            cpu_read(REG_PEND, v);
            checks++; if (v[5] !== exp_pend5[i]) begin errors++; $display("[TB] FAIL auto_pend5 step %0d: got %b expected %b", i, v[5], exp_pend5[i]); end
            checks++; if (intr[5] !== exp_intr5[i]) begin errors++; $display("[TB] FAIL auto_intr5 step %0d: got %b expected %b", i, intr[5], exp_intr5[i]); end
        end
        cpu_read(REG_TCTRL, v);
        checks++; if (v !== 32'h3) begin errors++; $display("[TB] FAIL auto_tctrl: got %h expected %h", v, 32'h3); end
        cpu_write(REG_TCTRL, 32'h0);
        cpu_write(REG_TCNT, 32'h0);
        cpu_write(REG_PEND, 32'h20);
        cpu_write(REG_MASK, 32'h0);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL auto_cleanup: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] v;
        cpu_write(REG_TCMP, 32'h2);
        cpu_write(REG_TCTRL, 32'h1);
        tick(1);
        cpu_read(REG_TCNT, v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL oneshot_tcnt1: got %h expected %h", v, 32'h1); end
        tick(2);
        cpu_read(REG_TCNT, v);
        checks++; if (v !== 32'h2) begin errors++; $display("[TB] FAIL oneshot_tcnt_stop: got %h expected %h", v, 32'h2); end
        cpu_read(REG_TCTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL oneshot_tctrl: got %h expected %h", v, 32'h0); end
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h20) begin errors++; $display("[TB] FAIL oneshot_pend: got %h expected %h", v, 32'h20); end
        tick(2);
        cpu_read(REG_TCNT, v);
        checks++; if (v !== 32'h2) begin errors++; $display("[TB] FAIL oneshot_hold: got %h expected %h", v, 32'h2); end
        cpu_write(REG_PEND, 32'h20);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL oneshot_w1c: got %h expected %h", v, 32'h0); end
        cpu_write(REG_TCNT, 32'h0);
        cpu_write(REG_TCTRL, 32'h1);
        tick(2);
        cpu_write(REG_PEND, 32'h20);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h20) begin errors++; $display("[TB] FAIL set_wins_pend: got %h expected %h", v, 32'h20); end
        cpu_read(REG_TCTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL set_wins_tctrl: got %h expected %h", v, 32'h0); end
        cpu_write(REG_PEND, 32'h20);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL oneshot_cleanup: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_decode_mask();
        logic [31:0] v;
        logic        s_o;
        cpu_read_addr(BASE + 32'h100, v, s_o);
        checks++; if (s_o !== 1'b0 || v !== 32'h0) begin errors++; $display("[TB] FAIL decode_miss: got sel %b rd %h expected 0 0", s_o, v); end
        cpu_write_addr(BASE + 32'h6, 32'h3C);
        cpu_read_addr(BASE + 32'h5, v, s_o);
        checks++; if (s_o !== 1'b1 || v !== 32'h3C) begin errors++; $display("[TB] FAIL decode_byte_off: got sel %b rd %h expected 1 %h", s_o, v, 32'h3C); end
        cpu_write_addr(BASE + 32'h104, 32'h01);
        cpu_read(REG_MASK, v);
        checks++; if (v !== 32'h3C) begin errors++; $display("[TB] FAIL decode_miss_write: got %h expected %h", v, 32'h3C); end
        cpu_write(3'd6, 32'hFFFF_FFFF);
        cpu_read(3'd6, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL decode_reg6: got %h expected %h", v, 32'h0); end
        cpu_write(REG_MASK, 32'h0);
        irq_ext[3] = 1'b1;
        tick(3);
        irq_ext[3] = 1'b0;
        tick(3);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h08) begin errors++; $display("[TB] FAIL mask_pend: got %h expected %h", v, 32'h08); end
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL mask_intr: got %h expected %h", intr, 6'h00); end
        intimer = 1'b1;
        #1;
        checks++; if (intr !== 6'h20) begin errors++; $display("[TB] FAIL intimer_pass: got %h expected %h", intr, 6'h20); end
        intimer = 1'b0;
        #1;
        checks++; if (intr !== 6'h00) begin errors++; $display("[TB] FAIL intimer_drop: got %h expected %h", intr, 6'h00); end
        tick(1);
        cpu_write(REG_PEND, 32'h08);
        cpu_read(REG_PEND, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL mask_cleanup: got %h expected %h", v, 32'h0); end
    endtask

    initial begin
        rst     = 1'b0;
        memCe   = 1'b0;
        memWr   = 1'b0;
        memAddr = '0;
        wtData  = '0;
        irq_ext = '0;
        intimer = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick(1);
        test_reset();
        test_edge();
        test_level();
        test_timer_auto();
        test_timer_oneshot();
        test_decode_mask();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
